wide_add_sequencer: RTL and testbench

- Multi-cycle wide adder that sits directly upstream of, and drives, the existing 16-bit manchester_adder. It slices WORDS*16-bit operands into 16-bit words and issues one word per clock to a single manchester_adder instance.
- It chains carry-out to carry-in between words through a register and assembles the full sum.
- Provides valid/ready handshakes on both the operand side and the result side. Used wherever operands wider than 16 bits must be added without replicating the adder.

---
 rtl/add_pkg.sv | 18 +
 rtl/wide_add_sequencer_if.sv | 29 ++
 rtl/manchester_adder.sv | 27 ++
 rtl/wide_add_sequencer.sv | 99 +++++++++
 tb/tb_wide_add_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the sliced wide adder.
// Defines the slice width, sequencer states and the signed-overflow rule.
package add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// master drives operands and accepts results; slave is the sequencer.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int W = WORDS * add_pkg::SLICE_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/manchester_adder.sv
// 16-bit adder built on a Manchester-style generate/propagate carry chain.
// Purely combinational; no handshake.
module manchester_adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [15:0] p;
    logic [15:0] g;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        logic carry;
        Sum   = '0;
        carry = Cin;
        for (int i = 0; i < 16; i++) begin
            Sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
        end
        Cout = carry;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS*16-bit adder that feeds one 16-bit slice per clock through a single manchester_adder.
// Result valid WORDS cycles after acceptance; result held in DONE until out_ready, no job overlap.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);
    import add_pkg::*;

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = $clog2(WORDS);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [W-1:0]         sum_q;
    logic                 cout_q;
    logic                 ovf_q;
    logic [SLICE_W-1:0]   add_sum;
    logic                 add_cout;
    logic                 last;

    assign last = (idx == IDX_W'(WORDS - 1));

    manchester_adder u_adder (
        .A    (a_q[idx*SLICE_W +: SLICE_W]),
        .B    (b_q[idx*SLICE_W +: SLICE_W]),
        .Cin  (carry),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so in_valid never reaches out_valid.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx*SLICE_W +: SLICE_W] <= add_sum;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout_q <= add_cout;
                        ovf_q  <= signed_ovf(a_q[W-1], b_q[W-1], add_sum[SLICE_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (WORDS=4): directed jobs, literal checks and a per-cycle model compare.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    // Behavioural model: a job is busy from acceptance, results appear WORDS edges later.
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [63:0] m_sum  = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (bus.in_valid === 1'b1) begin
                logic [64:0] t;
                t = {1'b0, bus.a} + {1'b0, bus.b} + {64'd0, bus.cin};
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_sum  <= t[63:0];
                m_cout <= t[64];
                m_ovf  <= (bus.a[63] == bus.b[63]) && (t[63] != bus.a[63]);
            end
        end else if (m_cnt < WORDS) begin
            m_cnt <= m_cnt + 1;
        end else if (bus.out_ready === 1'b1) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_ov;
        exp_ov = m_busy && (m_cnt == WORDS);
        check("model in_ready",  64'(bus.in_ready),  64'(!m_busy));
        check("model out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check("model sum",  bus.sum,         m_sum);
            check("model cout", 64'(bus.cout),   64'(m_cout));
            check("model ovf",  64'(bus.ovf),    64'(m_ovf));
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("accepted in_ready", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL wait_done: out_valid never rose within 40 cycles");
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post-handshake in_ready",  64'(bus.in_ready),  64'd1);
        check("post-handshake out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic check_result(input string name, input logic [63:0] s, input logic c, input logic o);
        check({name, " sum"},  bus.sum,       s);
        check({name, " cout"}, 64'(bus.cout), 64'(c));
        check({name, " ovf"},  64'(bus.ovf),  64'(o));
    endtask

    logic [63:0] vec_a   [3] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [63:0] vec_b   [3] = '{64'h1, 64'h0, 64'h1};
    logic        vec_cin [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] vec_sum [3] = '{64'h0000_0000_0001_0000, 64'h0, 64'h8000_0000_0000_0000};
    logic        vec_cout[3] = '{1'b0, 1'b1, 1'b0};
    logic        vec_ovf [3] = '{1'b0, 1'b0, 1'b1};
    string       vec_name[3] = '{"carry_chain", "full_wrap", "signed_ovf"};

    initial begin
        int          lat;
        logic [63:0] held;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check_result("reset", 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            send(vec_a[i], vec_b[i], vec_cin[i]);
            wait_done(lat);
            check({vec_name[i], " latency"}, 64'(lat), 64'd4);
            check_result(vec_name[i], vec_sum[i], vec_cout[i], vec_ovf[i]);
            consume();
        end

        // Backpressure: result must sit unchanged while out_ready is low.
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        wait_done(lat);
        check_result("backpressure", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        held = bus.sum;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp held sum",  bus.sum, 64'hFFFF_FFFF_FFFF_FFFF);
            check("bp out_valid", 64'(bus.out_valid), 64'd1);
            check("bp in_ready",  64'(bus.in_ready),  64'd0);
        end
        check("bp stable vs first", bus.sum, held);
        consume();

        // Reset mid-RUN after the second slice edge.
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst sum",       bus.sum,            64'h0);
        check("midrst in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'h1234_4321_1234_4321, 64'h4321_1234_4321_1234, 1'b0);
        wait_done(lat);
        check("after reset latency", 64'(lat), 64'd4);
        check_result("after reset", 64'h5555_5555_5555_5555, 1'b0, 1'b0);
        consume();

        // Back-to-back: in_valid stays high, operands change during the first job.
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = 64'h0000_0001_0000_0001;
        bus.b        = 64'h0000_0002_0000_0002;
        bus.cin      = 1'b0;
        @(posedge clk);
        #1;
        check("b2b first accepted", 64'(bus.in_ready), 64'd0);
        bus.a = 64'h00FF_00FF_00FF_00FF;
        bus.b = 64'h0001_0001_0001_0001;
        wait_done(lat);
        check_result("b2b first", 64'h0000_0003_0000_0003, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("b2b idle before second", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b second accepted", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        check("b2b second latency", 64'(lat), 64'd4);
        check_result("b2b second", 64'h0100_0100_0100_0100, 1'b0, 1'b0);
        consume();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
